mcb_host_fe: RTL and testbench

Single-outstanding host front-end that sits directly upstream of the SDRAM controller back-end (MCB) and issues its commands. It accepts one read or write request at a time from a simple host port and buffers up to 8 write beats. It launches the command on the `mcb_bb` strobe when the back-end is initialised and not busy, supplies write beats on `mcb_wdat_req`, and returns read beats from `mcb_rdat_vld`. It owns the host-address-to-bank/row/column mapping.

---
 rtl/mcb_host_fe_pkg.sv | 27 ++
 rtl/mcb_wbuf.sv | 23 ++
 rtl/mcb_host_fe.sv | 139 +++++++++++++
 tb/tb_mcb_host_fe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcb_host_fe_pkg.sv
// Shared definitions for the MCB host front-end: FSM encoding, burst decode,
// write-buffer geometry and default address-field widths.
package mcb_host_fe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WCOL  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WXFER = 3'd3,
    ST_RXFER = 3'd4
  } state_t;

  localparam int WBUF_DEPTH = 8;
  localparam int PTR_W      = 3;
  localparam int CNT_W      = 4;

  // Host word address is {ra, ba, ca}; bank sits above column so pages interleave banks.
  localparam int DEF_B_W = 2;
  localparam int DEF_R_W = 13;
  localparam int DEF_C_W = 9;
  localparam int DEF_D_W = 32;

  function automatic logic [CNT_W-1:0] bl_to_n(input logic [1:0] bl);
    return CNT_W'(1) << bl;
  endfunction

endpackage

// File: rtl/mcb_wbuf.sv
// Write-beat buffer: small register file, synchronous write, asynchronous read.
module mcb_wbuf
  import mcb_host_fe_pkg::*;
#(
  parameter int W = 36
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdat,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdat
);

  logic [W-1:0] mem [WBUF_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat = mem[raddr];

endmodule

// File: rtl/mcb_host_fe.sv
// Single-outstanding host front-end for the MCB back-end: accepts one request,
// buffers write beats, issues the command on mcb_bb and relays read beats.
module mcb_host_fe
  import mcb_host_fe_pkg::*;
#(
  parameter int MCB_B_W  = DEF_B_W,
  parameter int MCB_R_W  = DEF_R_W,
  parameter int MCB_C_W  = DEF_C_W,
  parameter int MCB_D_W  = DEF_D_W,
  parameter int MCB_BE_W = MCB_D_W / 8,
  parameter int HST_A_W  = MCB_R_W + MCB_B_W + MCB_C_W
) (
  input  logic                mcb_clk,
  input  logic                mcb_rst_n,
  input  logic                mcb_sclr_n,
  input  logic                hst_req,
  input  logic                hst_wr_n,
  input  logic [1:0]          hst_bl,
  input  logic [HST_A_W-1:0]  hst_addr,
  output logic                hst_ack,
  input  logic                hst_wdat_vld,
  input  logic [MCB_D_W-1:0]  hst_wdat,
  input  logic [MCB_BE_W-1:0] hst_wbe,
  output logic                hst_rdat_vld,
  output logic [MCB_D_W-1:0]  hst_rdat,
  output logic                hst_done,
  output logic                hst_err,
  output logic                mcb_bb,
  output logic                mcb_wr_n,
  output logic [1:0]          mcb_bl,
  output logic [MCB_B_W-1:0]  mcb_ba,
  output logic [MCB_R_W-1:0]  mcb_ra,
  output logic [MCB_C_W-1:0]  mcb_ca,
  input  logic                mcb_busy,
  input  logic                mcb_i_ready,
  input  logic                mcb_wdat_req,
  input  logic                mcb_rdat_vld,
  input  logic [MCB_D_W-1:0]  mcb_rdat,
  output logic [MCB_D_W-1:0]  mcb_wdat,
  output logic [MCB_BE_W-1:0] mcb_wbe
);

  localparam int BA_LSB = MCB_C_W;
  localparam int RA_LSB = MCB_C_W + MCB_B_W;
  localparam int BUF_W  = MCB_D_W + MCB_BE_W;

  logic             rst;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, n_beats;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             accept, wcap, issue, wreq, rbeat, last, err_set;
  logic [BUF_W-1:0] buf_rdat;

  assign rst     = !mcb_rst_n || !mcb_sclr_n;
  assign n_beats = bl_to_n(mcb_bl);

  always_comb begin
    accept  = (state == ST_IDLE) && hst_req;
    wcap    = (state == ST_WCOL) && hst_wdat_vld;
    issue   = (state == ST_ISSUE) && mcb_i_ready && !mcb_busy;
    wreq    = (state == ST_WXFER) && mcb_wdat_req;
    rbeat   = (state == ST_RXFER) && mcb_rdat_vld;
    // 4-bit compare so that beat 8 (cnt=7) does not alias to 0
    last    = (cnt + CNT_W'(1)) == n_beats;
    err_set = (hst_wdat_vld && state != ST_WCOL) ||
              (mcb_wdat_req && state != ST_WXFER) ||
              (mcb_rdat_vld && state != ST_RXFER);
  end

  always_ff @(posedge mcb_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (hst_req) state_nxt = hst_wr_n ? ST_ISSUE : ST_WCOL;
      ST_WCOL:  if (wcap && last) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue) state_nxt = mcb_wr_n ? ST_RXFER : ST_WXFER;
      ST_WXFER: if (wreq && last) state_nxt = ST_IDLE;
      ST_RXFER: if (rbeat && last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The command output registers double as the latched request fields.
  always_ff @(posedge mcb_clk) begin
    if (rst) begin
      hst_ack      <= 1'b0;
      hst_rdat_vld <= 1'b0;
      hst_rdat     <= '0;
      hst_done     <= 1'b0;
      hst_err      <= 1'b0;
      mcb_bb       <= 1'b0;
      mcb_wr_n     <= 1'b1;
      mcb_bl       <= '0;
      mcb_ba       <= '0;
      mcb_ra       <= '0;
      mcb_ca       <= '0;
      cnt          <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      hst_ack      <= accept;
      mcb_bb       <= issue;
      hst_rdat_vld <= rbeat;
      hst_done     <= (wreq || rbeat) && last;
      if (rbeat)   hst_rdat <= mcb_rdat;
      if (err_set) hst_err  <= 1'b1;
      if (accept) begin
        mcb_wr_n <= hst_wr_n;
        mcb_bl   <= hst_bl;
        mcb_ca   <= hst_addr[MCB_C_W-1:0];
        mcb_ba   <= hst_addr[BA_LSB +: MCB_B_W];
        mcb_ra   <= hst_addr[RA_LSB +: MCB_R_W];
        cnt      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end
      if (wcap || wreq || rbeat) cnt <= last ? '0 : cnt + CNT_W'(1);
      if (wcap) wr_ptr <= wr_ptr + PTR_W'(1);
      if (wreq) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  mcb_wbuf #(.W(BUF_W)) u_wbuf (
    .clk   (mcb_clk),
    .we    (wcap),
    .waddr (wr_ptr),
    .wdat  ({hst_wdat, hst_wbe}),
    .raddr (rd_ptr),
    .rdat  (buf_rdat)
  );

  // Gated so the write-data outputs read as zero outside a write transfer.
  assign {mcb_wdat, mcb_wbe} = (state == ST_WXFER) ? buf_rdat : '0;

endmodule

// File: tb/tb_mcb_host_fe.sv
// Bench for mcb_host_fe: table of transactions plus hand-written corner sequences,
// with queues of expected write/read beats checked as the DUT presents them.
module tb_mcb_host_fe;

  logic        mcb_clk = 1'b0;
  logic        mcb_rst_n, mcb_sclr_n;
  logic        hst_req, hst_wr_n;
  logic [1:0]  hst_bl;
  logic [23:0] hst_addr;
  logic        hst_ack;
  logic        hst_wdat_vld;
  logic [31:0] hst_wdat;
  logic [3:0]  hst_wbe;
  logic        hst_rdat_vld;
  logic [31:0] hst_rdat;
  logic        hst_done, hst_err;
  logic        mcb_bb, mcb_wr_n;
  logic [1:0]  mcb_bl;
  logic [1:0]  mcb_ba;
  logic [12:0] mcb_ra;
  logic [8:0]  mcb_ca;
  logic        mcb_busy, mcb_i_ready, mcb_wdat_req, mcb_rdat_vld;
  logic [31:0] mcb_rdat;
  logic [31:0] mcb_wdat;
  logic [3:0]  mcb_wbe;

  mcb_host_fe dut (
    .mcb_clk(mcb_clk), .mcb_rst_n(mcb_rst_n), .mcb_sclr_n(mcb_sclr_n),
    .hst_req(hst_req), .hst_wr_n(hst_wr_n), .hst_bl(hst_bl), .hst_addr(hst_addr),
    .hst_ack(hst_ack), .hst_wdat_vld(hst_wdat_vld), .hst_wdat(hst_wdat), .hst_wbe(hst_wbe),
    .hst_rdat_vld(hst_rdat_vld), .hst_rdat(hst_rdat), .hst_done(hst_done), .hst_err(hst_err),
    .mcb_bb(mcb_bb), .mcb_wr_n(mcb_wr_n), .mcb_bl(mcb_bl), .mcb_ba(mcb_ba),
    .mcb_ra(mcb_ra), .mcb_ca(mcb_ca), .mcb_busy(mcb_busy), .mcb_i_ready(mcb_i_ready),
    .mcb_wdat_req(mcb_wdat_req), .mcb_rdat_vld(mcb_rdat_vld), .mcb_rdat(mcb_rdat),
    .mcb_wdat(mcb_wdat), .mcb_wbe(mcb_wbe)
  );

  always #5 mcb_clk = ~mcb_clk;

  typedef struct {
    logic        wr_n;
    logic [1:0]  bl;
    logic [23:0] addr;
    logic [12:0] ra;
    logic [1:0]  ba;
    logic [8:0]  ca;
    logic [3:0]  wbe;
    logic [31:0] base;
    int          gap;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  int          bb_cnt = 0;
  logic        exp_wx = 1'b0;
  logic [31:0] rq[$];
  logic [35:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge mcb_clk);
    #1;
  endtask

  // Scoreboard side: compare beats as the DUT presents them.
  always @(negedge mcb_clk) begin
    if (hst_rdat_vld) begin
      if (rq.size() == 0) chk("rdat_unexpected", 1, 0);
      else chk("rdat", hst_rdat, rq.pop_front());
    end
    if (mcb_wdat_req && exp_wx) begin
      if (wq.size() == 0) chk("wdat_unexpected", 1, 0);
      else chk("wdat_wbe", {mcb_wdat, mcb_wbe}, wq.pop_front());
    end
    if (mcb_bb) bb_cnt++;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, hst_ack, 0);
    chk({tag, "_outs"}, {hst_rdat_vld, hst_done, hst_err, mcb_bb}, 0);
    chk({tag, "_rdat"}, hst_rdat, 0);
    chk({tag, "_wr_n"}, mcb_wr_n, 1);
    chk({tag, "_cmd"}, {mcb_bl, mcb_ba, mcb_ra, mcb_ca}, 0);
    chk({tag, "_wdat"}, {mcb_wdat, mcb_wbe}, 0);
  endtask

  task automatic start_txn(input vec_t v);
    int n = 1 << v.bl;
    hst_req = 1'b1; hst_wr_n = v.wr_n; hst_bl = v.bl; hst_addr = v.addr;
    tick();
    hst_req = 1'b0;
    chk("ack", hst_ack, 1);
    if (!v.wr_n) begin
      for (int i = 0; i < n; i++) begin
        hst_wdat_vld = 1'b1;
        hst_wdat = v.base + 32'(i);
        hst_wbe = v.wbe;
        wq.push_back({v.base + 32'(i), v.wbe});
        tick();
        chk("bb_early", mcb_bb, 0);
      end
      hst_wdat_vld = 1'b0;
    end
  endtask

  task automatic wait_bb(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mcb_bb && lat < 100);
    chk("bb_seen", mcb_bb, 1);
  endtask

  task automatic xfer(input vec_t v);
    int n = 1 << v.bl;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < (i % 2) * v.gap; g++) tick();
      if (v.wr_n) begin
        mcb_rdat_vld = 1'b1;
        mcb_rdat = v.base + 32'(i);
        rq.push_back(v.base + 32'(i));
      end else begin
        exp_wx = 1'b1;
        mcb_wdat_req = 1'b1;
      end
      tick();
      mcb_rdat_vld = 1'b0;
      mcb_wdat_req = 1'b0;
      if (i < n - 1) chk("done_early", hst_done, 0);
    end
    exp_wx = 1'b0;
    chk("done", hst_done, 1);
    if (v.wr_n) chk("done_with_rvld", hst_rdat_vld, 1);
    tick();
    chk("done_pulse", hst_done, 0);
    chk("no_err", hst_err, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    start_txn(v);
    wait_bb(lat);
    chk("bb_lat", lat, 1);
    chk("cmd_wr_n", mcb_wr_n, v.wr_n);
    chk("cmd_bl", mcb_bl, v.bl);
    chk("cmd_ra", mcb_ra, v.ra);
    chk("cmd_ba", mcb_ba, v.ba);
    chk("cmd_ca", mcb_ca, v.ca);
    xfer(v);
  endtask

  initial begin
    int   bb0, lat;
    vec_t h;
    vecs[0] = '{1'b1, 2'b00, 24'h000123, 13'h0000, 2'd0, 9'h123, 4'h0, 32'hD000_0000, 0};
    vecs[1] = '{1'b0, 2'b11, 24'hABCDEF, 13'h1579, 2'd2, 9'h1EF, 4'hF, 32'h0000_00A0, 0};
    vecs[2] = '{1'b1, 2'b10, 24'h000A00, 13'h0001, 2'd1, 9'h000, 4'h0, 32'hD000_0200, 2};
    vecs[3] = '{1'b0, 2'b01, 24'hFFFFFF, 13'h1FFF, 2'd3, 9'h1FF, 4'h5, 32'h1234_5600, 1};
    vecs[4] = '{1'b1, 2'b11, 24'h000200, 13'h0000, 2'd1, 9'h000, 4'h0, 32'hD000_0400, 1};
    vecs[5] = '{1'b0, 2'b00, 24'h000801, 13'h0001, 2'd0, 9'h001, 4'hA, 32'hCAFE_0000, 0};

    mcb_rst_n = 1'b0; mcb_sclr_n = 1'b1;
    hst_req = 1'b0; hst_wr_n = 1'b1; hst_bl = 2'b00; hst_addr = '0;
    hst_wdat_vld = 1'b0; hst_wdat = '0; hst_wbe = '0;
    mcb_busy = 1'b0; mcb_i_ready = 1'b1; mcb_wdat_req = 1'b0;
    mcb_rdat_vld = 1'b0; mcb_rdat = '0;
    repeat (3) tick();
    check_reset_outputs("rst");
    mcb_rst_n = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Command held off by not-ready then busy; fires once after both clear.
    h = '{1'b1, 2'b00, 24'h000045, 13'h0000, 2'd0, 9'h045, 4'h0, 32'hBEEF_0000, 0};
    mcb_i_ready = 1'b0;
    start_txn(h);
    bb0 = bb_cnt;
    repeat (20) tick();
    mcb_i_ready = 1'b1; mcb_busy = 1'b1;
    repeat (5) tick();
    chk("bb_held", bb_cnt, bb0);
    mcb_busy = 1'b0;
    tick();
    chk("bb_after_hold", mcb_bb, 1);
    chk("hold_ca", mcb_ca, 9'h045);
    tick();
    chk("bb_once", mcb_bb, 0);
    xfer(h);

    // Spurious write-data request while idle: sticky error, cleared by soft clear.
    mcb_wdat_req = 1'b1;
    tick();
    mcb_wdat_req = 1'b0;
    chk("err_set", hst_err, 1);
    repeat (4) tick();
    chk("err_sticky", hst_err, 1);
    mcb_sclr_n = 1'b0;
    tick();
    mcb_sclr_n = 1'b1;
    chk("err_clr", hst_err, 0);
    tick();

    // Reset in the middle of an 8-beat write transfer.
    h = '{1'b0, 2'b11, 24'h001234, 13'h0002, 2'd1, 9'h034, 4'hC, 32'h5500_0000, 0};
    start_txn(h);
    wait_bb(lat);
    exp_wx = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mcb_wdat_req = 1'b1;
      tick();
    end
    mcb_wdat_req = 1'b0;
    exp_wx = 1'b0;
    wq.delete();
    mcb_rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    mcb_rst_n = 1'b1;
    bb0 = bb_cnt;
    repeat (4) tick();
    chk("no_bb_after_rst", bb_cnt, bb0);
    h = '{1'b0, 2'b01, 24'h000010, 13'h0000, 2'd0, 9'h010, 4'h3, 32'h7700_0000, 0};
    run_vec(h);

    repeat (3) tick();
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
